// File: rtl/bounce_motion_ctrl.sv
// Per-frame motion stage for the bouncing logo: detects frame start from vpos,
// steps the top-left coordinate, reflects off the display edges and counts bounces.
module bounce_motion_ctrl #(
   parameter int OBJ_W   = 128,
   parameter int OBJ_H   = 128,
   parameter int DISP_W  = 640,
   parameter int DISP_H  = 480,
   parameter int START_X = 200,
   parameter int START_Y = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] vpos,
   input  logic       pause,
   input  logic [1:0] speed,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic       dir_x,
   output logic       dir_y,
   output logic [2:0] color_index,
   output logic       frame_tick,
   output logic       bounce_x,
   output logic       bounce_y
);

   localparam logic [10:0] LIM_X = 11'(DISP_W - OBJ_W);
   localparam logic [10:0] LIM_Y = 11'(DISP_H - OBJ_H);

   logic [9:0]  r_prev_vpos;
   logic        w_tick;
   logic [10:0] w_step;
   logic [9:0]  w_nx, w_ny;
   logic        w_ndx, w_ndy;
   logic        w_bx, w_by;

   // One axis step in 11 bits so an overshoot past the limit is seen, not wrapped.
   function automatic void advance(
      input  logic [9:0]  pos,
      input  logic        dir,
      input  logic [10:0] step,
      input  logic [10:0] lim,
      output logic [9:0]  npos,
      output logic        ndir,
      output logic        hit
   );
      logic [10:0] sum;
      sum  = {1'b0, pos} + step;
      npos = pos;
      ndir = dir;
      hit  = 1'b0;
      if (dir) begin
         if (sum >= lim) begin
            npos = lim[9:0];
            ndir = 1'b0;
            hit  = 1'b1;
         end else begin
            npos = sum[9:0];
         end
      end else begin
         if ({1'b0, pos} <= step) begin
            npos = '0;
            ndir = 1'b1;
            hit  = 1'b1;
         end else begin
            npos = pos - step[9:0];
         end
      end
   endfunction

   assign w_tick = (vpos == '0) && (r_prev_vpos != '0);
   assign w_step = {9'd0, speed} + 11'd1;

   always_comb begin
      w_nx  = pos_x;
      w_ny  = pos_y;
      w_ndx = dir_x;
      w_ndy = dir_y;
      w_bx  = 1'b0;
      w_by  = 1'b0;
      advance(pos_x, dir_x, w_step, LIM_X, w_nx, w_ndx, w_bx);
      advance(pos_y, dir_y, w_step, LIM_Y, w_ny, w_ndy, w_by);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev_vpos <= '0;
         pos_x       <= 10'(START_X);
         pos_y       <= 10'(START_Y);
         dir_x       <= 1'b1;
         dir_y       <= 1'b0;
         color_index <= '0;
         frame_tick  <= 1'b0;
         bounce_x    <= 1'b0;
         bounce_y    <= 1'b0;
      end else begin
         r_prev_vpos <= vpos;
         frame_tick  <= w_tick;
         bounce_x    <= 1'b0;
         bounce_y    <= 1'b0;
         if (w_tick && !pause) begin
            pos_x    <= w_nx;
            pos_y    <= w_ny;
            dir_x    <= w_ndx;
            dir_y    <= w_ndy;
            bounce_x <= w_bx;
            bounce_y <= w_by;
            // A corner hit still advances the colour by one.
            if (w_bx || w_by)
               color_index <= color_index + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_bounce_motion_ctrl.sv
// Randomized bench for bounce_motion_ctrl against a per-frame velocity/clamp model.
module tb_bounce_motion_ctrl;

   localparam int LX = 640 - 128;
   localparam int LY = 480 - 128;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] vpos;
   logic       pause;
   logic [1:0] speed;
   logic [9:0] pos_x, pos_y;
   logic       dir_x, dir_y;
   logic [2:0] color_index;
   logic       frame_tick, bounce_x, bounce_y;

   int n_vec = 0;
   int n_err = 0;

   // reference state
   int m_prev, m_x, m_y, m_col;
   bit m_dx, m_dy, m_tick, m_bx, m_by;

   always #5 clk = ~clk;

   bounce_motion_ctrl #(
      .OBJ_W(128), .OBJ_H(128), .DISP_W(640), .DISP_H(480),
      .START_X(200), .START_Y(200)
   ) dut (
      .clk(clk), .reset(reset), .vpos(vpos), .pause(pause), .speed(speed),
      .pos_x(pos_x), .pos_y(pos_y), .dir_x(dir_x), .dir_y(dir_y),
      .color_index(color_index), .frame_tick(frame_tick),
      .bounce_x(bounce_x), .bounce_y(bounce_y)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Signed velocity, move, then clamp; touching or crossing an edge reflects.
   task automatic model_axis(inout int p, inout bit d, output bit hit, input int step, input int lim);
      int t;
      t   = p + (d ? step : -step);
      hit = (t <= 0) || (t >= lim);
      if (hit) begin
         p = (t <= 0) ? 0 : lim;
         d = !d;
      end else begin
         p = t;
      end
   endtask

   task automatic model_update(input logic rst, input logic [9:0] vp, input logic pa, input logic [1:0] sp);
      if (rst) begin
         m_prev = 0; m_x = 200; m_y = 200; m_dx = 1; m_dy = 0; m_col = 0;
         m_tick = 0; m_bx = 0; m_by = 0;
         return;
      end
      m_tick = (vp == 0) && (m_prev != 0);
      m_bx = 0;
      m_by = 0;
      if (m_tick && !pa) begin
         model_axis(m_x, m_dx, m_bx, int'(sp) + 1, LX);
         model_axis(m_y, m_dy, m_by, int'(sp) + 1, LY);
         if (m_bx || m_by) m_col = (m_col + 1) % 8;
      end
      m_prev = int'(vp);
   endtask

   task automatic compare_all();
      chk("pos_x", 32'(pos_x), 32'(m_x));
      chk("pos_y", 32'(pos_y), 32'(m_y));
      chk("dir_x", 32'(dir_x), 32'(m_dx));
      chk("dir_y", 32'(dir_y), 32'(m_dy));
      chk("color_index", 32'(color_index), 32'(m_col));
      chk("frame_tick", 32'(frame_tick), 32'(m_tick));
      chk("bounce_x", 32'(bounce_x), 32'(m_bx));
      chk("bounce_y", 32'(bounce_y), 32'(m_by));
   endtask

   task automatic cyc(input logic rst, input logic [9:0] vp, input logic pa, input logic [1:0] sp);
      reset = rst; vpos = vp; pause = pa; speed = sp;
      @(posedge clk);
      model_update(rst, vp, pa, sp);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      int ticks;
      int run;
      reset = 1'b1; vpos = '0; pause = 1'b0; speed = '0;
      m_prev = 0; m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_col = 0;
      m_tick = 0; m_bx = 0; m_by = 0;

      // reset, then no spurious tick while vpos leaves 0
      repeat (3) cyc(1'b1, 10'd0, 1'b0, 2'd0);
      cyc(1'b0, 10'd0, 1'b0, 2'd0);
      cyc(1'b0, 10'd5, 1'b0, 2'd0);
      chk("reset_pos_x", 32'(pos_x), 32'd200);
      chk("reset_pos_y", 32'(pos_y), 32'd200);

      // vpos held at 0 for 800 cycles gives exactly one tick
      cyc(1'b0, 10'd524, 1'b0, 2'd0);
      ticks = 0;
      for (int i = 0; i < 800; i++) begin
         cyc(1'b0, 10'd0, 1'b0, 2'd0);
         if (frame_tick === 1'b1) ticks++;
      end
      chk("one_tick", 32'(ticks), 32'd1);
      chk("first_step_x", 32'(pos_x), 32'd201);
      chk("first_step_y", 32'(pos_y), 32'd199);

      // randomized frames with occasional pause and rare reset
      for (int f = 0; f < 2500; f++) begin
         run = $urandom_range(1, 8);
         for (int i = 0; i < run; i++)
            cyc(($urandom % 3000) == 0, 10'($urandom_range(1, 524)),
                ($urandom % 8) == 0, 2'($urandom));
         run = $urandom_range(1, 4);
         for (int i = 0; i < run; i++)
            cyc(($urandom % 3000) == 0, 10'd0, ($urandom % 8) == 0, 2'($urandom));
      end

      // reset landing in the frame_tick cycle drops the pulse
      cyc(1'b0, 10'd3, 1'b0, 2'd3);
      cyc(1'b0, 10'd0, 1'b0, 2'd3);
      chk("tick_before_reset", 32'(frame_tick), 32'd1);
      cyc(1'b1, 10'd0, 1'b0, 2'd3);
      chk("reset_in_tick_x", 32'(pos_x), 32'd200);
      chk("reset_in_tick_tick", 32'(frame_tick), 32'd0);
      cyc(1'b0, 10'd0, 1'b0, 2'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
